// File: rtl/mbe_pp_accumulator.sv
// Radix-8 MBE partial-product accumulator: reduces PPRU row sets into the mantissa product.
// Define MBE_ACC_STICKY_EN to add the registered o_sticky output.
package booth_pkg;
    localparam int NBIT_MANTISSA = 23;
    localparam int NBLOCK_BE     = 9;
    localparam int NBIT_PP       = NBIT_MANTISSA + 4;
    localparam int NBIT_US       = 4;

    typedef struct packed {
        logic [NBIT_US-1:0] upper_signs;
        logic [NBIT_PP-1:0] pp_extended;
        logic               lower_sign;
    } t_o_ppru;
endpackage

module mbe_pp_accumulator #(
    parameter int  NBIT_MANTISSA  = booth_pkg::NBIT_MANTISSA,
    parameter int  NBLOCK_BE      = booth_pkg::NBLOCK_BE,
    parameter int  ROWS_PER_CYCLE = 3,
    localparam int NPW            = 2 * (NBIT_MANTISSA + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_valid,
    output logic                                o_ready,
    input  booth_pkg::t_o_ppru [NBLOCK_BE-1:0]  i_rows,
    output logic                                o_valid,
    input  logic                                i_ready,
    output logic [NPW-1:0]                      o_product
`ifdef MBE_ACC_STICKY_EN
    ,
    output logic                                o_sticky
`endif
);
    localparam int NACC = NBLOCK_BE / ROWS_PER_CYCLE;
    localparam int CW   = (NACC > 1) ? $clog2(NACC) : 1;
    localparam logic [CW-1:0] LAST = CW'(NACC - 1);

    if (NBLOCK_BE % ROWS_PER_CYCLE != 0) begin : g_bad_rpc
        $error("mbe_pp_accumulator: NBLOCK_BE must be a multiple of ROWS_PER_CYCLE");
    end

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                             state;
    booth_pkg::t_o_ppru [NBLOCK_BE-1:0] row_buf;
    logic [NPW-1:0]                     acc;
    logic [NPW-1:0]                     acc_nxt;
    logic [CW-1:0]                      cnt;
    logic                               accept;

    // Row value plus its negation carry, placed at weight 2^(3*idx).
    function automatic logic [NPW-1:0] row_term(
        input booth_pkg::t_o_ppru r,
        input int                 idx
    );
        logic [NPW-1:0] w;
        w = NPW'({r.upper_signs, r.pp_extended}) + NPW'(r.lower_sign);
        return w << (3 * idx);
    endfunction

    always_comb begin
        acc_nxt = acc;
        for (int j = 0; j < NBLOCK_BE; j++) begin
            if (CW'(j / ROWS_PER_CYCLE) == cnt) begin
                acc_nxt = acc_nxt + row_term(row_buf[j], j);
            end
        end
    end

    assign o_ready   = (state == IDLE) || ((state == DONE) && i_ready);
    assign accept    = i_valid && o_ready;
    assign o_product = acc;

`ifdef MBE_ACC_STICKY_EN
    logic sticky_q;
    assign o_sticky = sticky_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            row_buf <= '0;
            acc     <= '0;
            cnt     <= '0;
            o_valid <= 1'b0;
`ifdef MBE_ACC_STICKY_EN
            sticky_q <= 1'b0;
`endif
        end else if (accept) begin
            state   <= ACCUM;
            row_buf <= i_rows;
            acc     <= '0;
            cnt     <= '0;
            o_valid <= 1'b0;
`ifdef MBE_ACC_STICKY_EN
            sticky_q <= 1'b0;
`endif
        end else begin
            unique case (state)
                ACCUM: begin
                    acc <= acc_nxt;
`ifdef MBE_ACC_STICKY_EN
                    sticky_q <= |acc_nxt[NBIT_MANTISSA-2:0];
`endif
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        state   <= DONE;
                        o_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mbe_pp_accumulator.sv
// Randomized self-checking bench for mbe_pp_accumulator against an A*B reference.
// Rows come from a radix-8 Booth encode/select/PPRU model; products are plain multiplies.
module tb_mbe_pp_accumulator;
    import booth_pkg::*;

    localparam int NB   = NBLOCK_BE;
    localparam int NACC = 3;
    localparam int NR   = 1500;

    typedef t_o_ppru [NB-1:0] rows_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_ready, o_ready, o_valid;
    rows_t       i_rows;
    logic [47:0] o_product;
    logic        a_valid, a_ready;
    rows_t       a_rows;
    logic        o_ready1, o_valid1, o_ready9, o_valid9;
    logic [47:0] o_product1, o_product9;
`ifdef MBE_ACC_STICKY_EN
    logic        o_sticky, o_sticky1, o_sticky9;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mbe_pp_accumulator #(.ROWS_PER_CYCLE(3)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .o_ready(o_ready), .i_rows(i_rows),
        .o_valid(o_valid), .i_ready(i_ready), .o_product(o_product)
`ifdef MBE_ACC_STICKY_EN
        , .o_sticky(o_sticky)
`endif
    );

    mbe_pp_accumulator #(.ROWS_PER_CYCLE(1)) dut_r1 (
        .clk(clk), .rst(rst),
        .i_valid(a_valid), .o_ready(o_ready1), .i_rows(a_rows),
        .o_valid(o_valid1), .i_ready(a_ready), .o_product(o_product1)
`ifdef MBE_ACC_STICKY_EN
        , .o_sticky(o_sticky1)
`endif
    );

    mbe_pp_accumulator #(.ROWS_PER_CYCLE(9)) dut_r9 (
        .clk(clk), .rst(rst),
        .i_valid(a_valid), .o_ready(o_ready9), .i_rows(a_rows),
        .o_valid(o_valid9), .i_ready(a_ready), .o_product(o_product9)
`ifdef MBE_ACC_STICKY_EN
        , .o_sticky(o_sticky9)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Radix-8 Booth digits of b select multiples of a; negative rows are
    // inverted with a lower_sign carry, sign extension folded into upper_signs.
    function automatic rows_t gen_rows(input logic [23:0] a, input logic [23:0] b);
        rows_t       r;
        logic [27:0] bx;
        logic [3:0]  g;
        logic [26:0] mag;
        logic        s;
        int          d;
        bx = {3'b000, b, 1'b0};
        for (int i = 0; i < NB; i++) begin
            g   = bx[3*i +: 4];
            d   = -4 * int'(g[3]) + 2 * int'(g[2]) + int'(g[1]) + int'(g[0]);
            s   = (d < 0);
            mag = 27'(a) * 27'(s ? -d : d);
            r[i].lower_sign  = s;
            r[i].pp_extended = s ? ~mag : mag;
            r[i].upper_signs = (i == 0) ? {~s, s, s, s} : {1'b0, 1'b1, 1'b1, ~s};
        end
        return r;
    endfunction

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!o_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input logic [23:0] a, input logic [23:0] b, input string tag);
        int          lat;
        logic [47:0] exp;
        exp = 48'(a) * 48'(b);
        @(negedge clk);
        i_rows  = gen_rows(a, b);
        i_valid = 1'b1;
        i_ready = 1'b1;
        #1 check({tag, "_rdy"}, 64'(o_ready), 64'(1));
        @(negedge clk);
        i_valid = 1'b0;
        wait_valid(lat);
        check({tag, "_lat"}, 64'(lat), 64'(NACC));
        check({tag, "_prod"}, 64'(o_product), 64'(exp));
`ifdef MBE_ACC_STICKY_EN
        check({tag, "_stk"}, 64'(o_sticky), 64'(|exp[21:0]));
`endif
    endtask

    task automatic run_alt(input logic [23:0] a, input logic [23:0] b);
        int          l1, l9;
        logic [47:0] p1, p9, exp;
        exp = 48'(a) * 48'(b);
        l1 = -1;
        l9 = -1;
        p1 = '0;
        p9 = '0;
        @(negedge clk);
        a_rows  = gen_rows(a, b);
        a_valid = 1'b1;
        a_ready = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        for (int n = 0; n < 40 && (l1 < 0 || l9 < 0); n++) begin
            if (o_valid1 && l1 < 0) begin l1 = n; p1 = o_product1; end
            if (o_valid9 && l9 < 0) begin l9 = n; p9 = o_product9; end
            @(negedge clk);
        end
        check("rpc1_lat", 64'(l1), 64'(9));
        check("rpc1_prod", 64'(p1), 64'(exp));
        check("rpc9_lat", 64'(l9), 64'(1));
        check("rpc9_prod", 64'(p9), 64'(exp));
    endtask

    task automatic run_backpressure();
        int          lat;
        logic [47:0] ex, ey;
        logic [23:0] ya, yb;
        ya = 24'($urandom) | 24'h800000;
        yb = 24'($urandom) | 24'h800000;
        ex = 48'(24'hFFFFFF) * 48'(24'hABCDEF);
        ey = 48'(ya) * 48'(yb);
        @(negedge clk);
        i_rows  = gen_rows(24'hFFFFFF, 24'hABCDEF);
        i_valid = 1'b1;
        i_ready = 1'b0;
        @(negedge clk);
        i_rows = gen_rows(ya, yb);
        #1 check("bp_busy_rdy", 64'(o_ready), 64'(0));
        wait_valid(lat);
        check("bp_lat", 64'(lat), 64'(NACC));
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_hold_vld", 64'(o_valid), 64'(1));
            check("bp_hold_prod", 64'(o_product), 64'(ex));
            check("bp_hold_rdy", 64'(o_ready), 64'(0));
            @(negedge clk);
        end
        i_ready = 1'b1;
        #1 check("bp_pass_rdy", 64'(o_ready), 64'(1));
        @(negedge clk);
        check("bp_b2b_vld", 64'(o_valid), 64'(0));
        i_valid = 1'b0;
        wait_valid(lat);
        check("bp_b2b_lat", 64'(lat), 64'(NACC));
        check("bp_b2b_prod", 64'(o_product), 64'(ey));
    endtask

    task automatic run_reset_mid();
        @(negedge clk);
        i_rows  = gen_rows(24'hFEDCBA, 24'hC0FFEE);
        i_valid = 1'b1;
        i_ready = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_vld", 64'(o_valid), 64'(0));
        check("rst_mid_prod", 64'(o_product), 64'(0));
        #2 rst = 1'b0;
        #1 check("rst_mid_rdy", 64'(o_ready), 64'(1));
        run_op(24'h000003, 24'h000005, "after_rst");
    endtask

    task automatic run_random();
        logic [47:0] q[$];
        logic [47:0] cur;
        logic [23:0] a, b;
        logic        exp_rdy, drop;
        int          pend, sent, got;
        pend    = -1;
        sent    = 0;
        got     = 0;
        drop    = 1'b0;
        cur     = '0;
        i_valid = 1'b0;
        for (int cyc = 0; cyc < 40000 && got < NR; cyc++) begin
            @(negedge clk);
            if (drop) i_valid = 1'b0;
            drop = 1'b0;
            if (!i_valid && sent < NR && $urandom_range(3) != 0) begin
                a = 24'($urandom);
                b = 24'($urandom);
                if ($urandom_range(15) == 0) a = 24'hFFFFFF;
                if ($urandom_range(15) == 0) b = 24'h800000;
                cur     = 48'(a) * 48'(b);
                i_rows  = gen_rows(a, b);
                i_valid = 1'b1;
            end
            i_ready = ($urandom_range(2) != 0);
            exp_rdy = (pend < 0) || (pend == 0 && i_ready);
            #1;
            check("rnd_vld", 64'(o_valid), 64'(pend == 0));
            check("rnd_rdy", 64'(o_ready), 64'(exp_rdy));
            if (pend == 0 && q.size() > 0) begin
                check("rnd_prod", 64'(o_product), 64'(q[0]));
`ifdef MBE_ACC_STICKY_EN
                check("rnd_stk", 64'(o_sticky), 64'(|q[0][21:0]));
`endif
            end
            if (pend == 0 && i_ready) begin
                void'(q.pop_front());
                got++;
                pend = -1;
            end else if (pend > 0) begin
                pend--;
            end
            if (i_valid && exp_rdy) begin
                q.push_back(cur);
                pend = NACC;
                sent++;
                drop = 1'b1;
            end
        end
        check("rnd_count", 64'(got), 64'(NR));
        check("rnd_left", 64'(q.size()), 64'(0));
    endtask

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_rows  = '0;
        a_valid = 1'b0;
        a_ready = 1'b0;
        a_rows  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_vld", 64'(o_valid), 64'(0));
        check("rst_prod", 64'(o_product), 64'(0));
        check("rst_rdy", 64'(o_ready), 64'(1));
        check("rst_vld_r1", 64'(o_valid1), 64'(0));
        check("rst_vld_r9", 64'(o_valid9), 64'(0));
`ifdef MBE_ACC_STICKY_EN
        check("rst_stk", 64'(o_sticky), 64'(0));
`endif
        run_op(24'hFFFFFF, 24'hFFFFFF, "ones");
        run_op(24'h800000, 24'h800000, "msb");
        run_op(24'hABCDEF, 24'h000001, "unit");
        run_alt(24'h800000, 24'h800000);
        run_alt(24'hFFFFFF, 24'hFFFFFF);
        run_backpressure();
        run_reset_mid();
        run_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
